// File: rtl/keyboard_event_arbiter.sv
// keyboard_event_arbiter
// Shares the keyboard-matrix scancode strobe between the live PS/2 key-event
// stream and a host injection port used for typed-text paste. Each injected key
// becomes a paced press/hold/release sequence, optionally wrapped in shift.
// Every trigger, live or injected, respects a minimum spacing of GAP_CYCLES.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no injection in flight; host may hand over a new key
// SHIFT_DN | waiting for a slot to emit the shift press
// KEY_DN   | waiting for a slot to emit the injected key press
// HOLD     | injected key held down, hold timer running
// KEY_UP   | waiting for a slot to emit the injected key release
// SHIFT_UP | waiting for a slot to emit the shift release

module keyboard_event_arbiter #(
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned HOLD_CYCLES = 2000000,
    parameter int unsigned CNT_W       = 24,
    parameter logic [6:0]  SHIFT_CODE  = 7'h0f
) (
    input  logic       clk,
    input  logic       reset_n,

    input  logic       live_valid,
    input  logic [6:0] live_scancode,
    input  logic       live_pressed,
    output logic       live_ready,

    input  logic       inj_valid,
    input  logic [6:0] inj_scancode,
    input  logic       inj_shift,
    output logic       inj_ready,
    input  logic       inj_abort,
    output logic       inj_busy,

    output logic [6:0] scancode,
    output logic       pressed,
    output logic       trigger
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT_DN = 3'd1,
        S_KEY_DN   = 3'd2,
        S_HOLD     = 3'd3,
        S_KEY_UP   = 3'd4,
        S_SHIFT_UP = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] gap_q,      gap_d;
    logic [CNT_W-1:0] hold_q,     hold_d;
    logic [6:0]       code_q,     code_d;
    logic             shift_q,    shift_d;
    logic [6:0]       scancode_q, scancode_d;
    logic             pressed_q,  pressed_d;
    logic             trigger_q,  trigger_d;
    logic             busy_q,     busy_d;

    logic emit_ok;
    logic inj_slot;

    // A slot opens once the gap timer has drained and no strobe is in flight;
    // injected emissions only get slots the live stream leaves unused.
    always_comb begin
        emit_ok    = (gap_q == CNT_ZERO) && !trigger_q;
        inj_slot   = emit_ok && !live_valid;
        live_ready = emit_ok;
        inj_ready  = (state_q == S_IDLE) && emit_ok && !live_valid && !inj_abort;
    end

    // Next-state, emission selection and timer update.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        shift_d    = shift_q;
        scancode_d = scancode_q;
        pressed_d  = pressed_q;
        trigger_d  = 1'b0;
        gap_d      = (gap_q != CNT_ZERO) ? gap_q - CNT_ONE : CNT_ZERO;
        hold_d     = (hold_q != CNT_ZERO) ? hold_q - CNT_ONE : CNT_ZERO;

        if (live_valid && emit_ok) begin
            trigger_d  = 1'b1;
            scancode_d = live_scancode;
            pressed_d  = live_pressed;
        end

        unique case (state_q)
            S_IDLE: begin
                if (inj_valid && inj_ready) begin
                    code_d  = inj_scancode;
                    shift_d = inj_shift;
                    state_d = inj_shift ? S_SHIFT_DN : S_KEY_DN;
                end
            end
            S_SHIFT_DN: begin
                if (inj_abort) begin
                    state_d = S_IDLE;
                end else if (inj_slot) begin
                    trigger_d  = 1'b1;
                    scancode_d = SHIFT_CODE;
                    pressed_d  = 1'b1;
                    state_d    = S_KEY_DN;
                end
            end
            S_KEY_DN: begin
                // Shift may already be down, so an abort here still has to
                // release it.
                if (inj_abort) begin
                    state_d = shift_q ? S_SHIFT_UP : S_IDLE;
                end else if (inj_slot) begin
                    trigger_d  = 1'b1;
                    scancode_d = code_q;
                    pressed_d  = 1'b1;
                    hold_d     = HOLD_LOAD;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // Leave as the timer reaches zero so that, with a free slot,
                // the release lands exactly HOLD_CYCLES after the press.
                if (inj_abort || (hold_q <= CNT_ONE)) begin
                    state_d = S_KEY_UP;
                end
            end
            S_KEY_UP: begin
                if (inj_slot) begin
                    trigger_d  = 1'b1;
                    scancode_d = code_q;
                    pressed_d  = 1'b0;
                    state_d    = shift_q ? S_SHIFT_UP : S_IDLE;
                end
            end
            S_SHIFT_UP: begin
                if (inj_slot) begin
                    trigger_d  = 1'b1;
                    scancode_d = SHIFT_CODE;
                    pressed_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (trigger_d) begin
            gap_d = GAP_LOAD;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, timers and registered matrix outputs; reset drops everything
    // without emitting a release since the matrix is reset alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gap_q      <= CNT_ZERO;
            hold_q     <= CNT_ZERO;
            code_q     <= 7'h00;
            shift_q    <= 1'b0;
            scancode_q <= 7'h00;
            pressed_q  <= 1'b0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
            code_q     <= code_d;
            shift_q    <= shift_d;
            scancode_q <= scancode_d;
            pressed_q  <= pressed_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
        end
    end

    assign scancode = scancode_q;
    assign pressed  = pressed_q;
    assign trigger  = trigger_q;
    assign inj_busy = busy_q;

endmodule
